// File: rtl/nes_frame_scheduler.sv
// Frame buffer arbiter: shares one synchronous-read RAM between PPU writes and
// 2x-scaled VGA scan-out, with a frame-aligned double-buffer bank swap.
module nes_frame_scheduler #(
  parameter int          H_OFFSET     = 64,
  parameter logic [7:0]  BORDER_PIXEL = 8'h0F,
  parameter int          LAST_COL     = 799,
  parameter int          LAST_ROW     = 524
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  column_i,
  input  logic [9:0]  row_i,
  output logic [7:0]  pixel_o,
  input  logic        wr_valid_i,
  input  logic [15:0] wr_addr_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ready_o,
  input  logic        swap_req_i,
  output logic        swap_done_o,
  output logic        display_bank_o,
  output logic [16:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_wdata_o,
  input  logic [7:0]  ram_rdata_i
);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t      state_q, state_d;
  logic        rd_pending_q, rd_pending_d;
  logic        bank_q, bank_d;
  logic [7:0]  pixel_q, pixel_d;
  logic        rd_slot, swap_point, swap_fire, win_next, active_row;
  logic [9:0]  col_off, col_nxt;
  logic [7:0]  rd_x, rd_y;

  // Reads run two columns ahead: one cycle of RAM latency plus one output register.
  assign active_row = row_i < 10'd480;
  assign rd_slot    = active_row && !column_i[0] &&
                      column_i >= 10'(H_OFFSET - 2) && column_i <= 10'(H_OFFSET + 509);
  assign col_off    = column_i - 10'(H_OFFSET - 2);
  assign rd_x       = col_off[8:1];
  assign rd_y       = row_i[8:1];
  assign col_nxt    = column_i + 10'd1;
  assign win_next   = active_row && col_nxt >= 10'(H_OFFSET) && col_nxt <= 10'(H_OFFSET + 511);

  // Reads own the port in their slot; writes go to the back bank otherwise.
  assign wr_ready_o  = !rd_slot;
  assign ram_we_o    = wr_valid_i && !rd_slot;
  assign ram_addr_o  = ram_we_o ? {~bank_q, wr_addr_i} : {bank_q, rd_y, rd_x};
  assign ram_wdata_o = wr_data_i;

  assign swap_point = column_i == 10'(LAST_COL) && row_i == 10'(LAST_ROW);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rd_pending_q <= 1'b0;
      bank_q       <= 1'b0;
      pixel_q      <= BORDER_PIXEL;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      bank_q       <= bank_d;
      pixel_q      <= pixel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (swap_req_i && !swap_point) state_d = S_PENDING;
      S_PENDING: if (swap_point)                state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // A request landing exactly on the swap point flips without visiting PENDING.
  always_comb begin
    swap_fire   = swap_point && (state_q == S_PENDING || swap_req_i);
    swap_done_o = swap_fire && !rst_i;
  end

  always_comb begin
    rd_pending_d = rd_slot;
    bank_d       = bank_q ^ swap_fire;
    pixel_d      = pixel_q;
    if (rd_pending_q)   pixel_d = ram_rdata_i;
    else if (!win_next) pixel_d = BORDER_PIXEL;
  end

  assign pixel_o        = pixel_q;
  assign display_bank_o = bank_q;

endmodule

// File: tb/tb_nes_frame_scheduler.sv
// Directed bench for nes_frame_scheduler with a behavioural synchronous RAM.
module tb_nes_frame_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  column_i, row_i;
  logic [7:0]  pixel_o;
  logic        wr_valid_i;
  logic [15:0] wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        wr_ready_o, swap_req_i, swap_done_o, display_bank_o;
  logic [16:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_wdata_o, ram_rdata_i;

  logic [7:0]  mem [0:131071];
  int n_vec = 0;
  int n_err = 0;

  nes_frame_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .column_i(column_i), .row_i(row_i), .pixel_o(pixel_o),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .swap_req_i(swap_req_i), .swap_done_o(swap_done_o),
    .display_bank_o(display_bank_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Bank 0 holds x^y, bank 1 holds x+2y.
  initial begin
    ram_rdata_i = 8'h00;
    for (int a = 0; a < 65536; a++) begin
      mem[a]         = 8'(a[7:0] ^ a[15:8]);
      mem[65536 + a] = 8'(a[7:0] + 2 * a[15:8]);
    end
    forever begin
      @(posedge clk_i);
      ram_rdata_i <= mem[ram_addr_o];
      if (ram_we_o) mem[ram_addr_o] = ram_wdata_o;
    end
  end

  function automatic logic [7:0] exp_pix(input int c, input int r, input bit b);
    int x, y;
    if (r < 480 && c >= 64 && c <= 575) begin
      x = (c - 64) >> 1;
      y = r >> 1;
      return b ? 8'(x + 2 * y) : 8'(x ^ y);
    end
    return 8'h0F;
  endfunction

  task automatic step(input int c, input int r);
    @(posedge clk_i);
    #1;
    column_i = 10'(c);
    row_i    = 10'(r);
  endtask

  task automatic run_row(input int r, input bit b);
    logic [7:0] e;
    step(799, 500);
    step(799, 500);
    for (int c = 0; c < 800; c++) begin
      step(c, r);
      @(negedge clk_i);
      e = exp_pix(c, r, b);
      n_vec++;
      if (pixel_o !== e) begin
        n_err++;
        $display("FAIL scan r=%0d c=%0d bank=%0d got %h want %h", r, c, b, pixel_o, e);
      end
    end
  endtask

  task automatic chk_swap(input string nm, input logic done_e, input logic bank_e);
    @(negedge clk_i);
    n_vec++;
    if (swap_done_o !== done_e || display_bank_o !== bank_e) begin
      n_err++;
      $display("FAIL %s done/bank got %b/%b want %b/%b", nm, swap_done_o, display_bank_o, done_e, bank_e);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; column_i = 10'd300; row_i = 10'd100;
    wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; swap_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if (pixel_o !== 8'h0F || ram_we_o !== 1'b0 || display_bank_o !== 1'b0 || swap_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset pix/we/bank/done got %h/%b/%b/%b want 0f/0/0/0",
               pixel_o, ram_we_o, display_bank_o, swap_done_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_scanout;
    run_row(0, 1'b0);
    run_row(1, 1'b0);
    run_row(238, 1'b0);
    run_row(479, 1'b0);
    run_row(480, 1'b0);
  endtask

  task automatic test_arbitration;
    int  k = 0;
    bit  rdy;
    step(799, 500);
    wr_valid_i = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step(c, 10);
      wr_addr_i = 16'(200 * 256 + k);
      wr_data_i = 8'(k * 7 + 1);
      @(negedge clk_i);
      rdy = !((c % 2 == 0) && c >= 62 && c <= 572);
      n_vec++;
      if (wr_ready_o !== rdy || ram_we_o !== rdy) begin
        n_err++;
        $display("FAIL arb c=%0d ready/we got %b/%b want %b/%b", c, wr_ready_o, ram_we_o, rdy, rdy);
      end
      if (rdy) begin
        n_vec++;
        if (ram_addr_o !== {1'b1, wr_addr_i} || ram_wdata_o !== wr_data_i) begin
          n_err++;
          $display("FAIL arb_addr c=%0d got %h/%h want %h/%h", c, ram_addr_o, ram_wdata_o,
                   {1'b1, wr_addr_i}, wr_data_i);
        end
        k++;
      end
    end
    step(0, 500);
    wr_valid_i = 1'b0;
    n_vec++;
    if (k != 544) begin
      n_err++;
      $display("FAIL arb_count got %0d want 544", k);
    end
    for (int i = 0; i < k; i++) begin
      n_vec++;
      if (mem[17'(65536 + 200 * 256 + i)] !== 8'(i * 7 + 1)) begin
        n_err++;
        $display("FAIL arb_mem i=%0d got %h want %h", i, mem[17'(65536 + 200 * 256 + i)], 8'(i * 7 + 1));
      end
    end
  endtask

  task automatic test_swap;
    step(0, 100);   swap_req_i = 1'b1; chk_swap("swap_req", 1'b0, 1'b0);
    step(1, 100);   swap_req_i = 1'b0; chk_swap("swap_wait", 1'b0, 1'b0);
    step(798, 524); chk_swap("swap_pre", 1'b0, 1'b0);
    step(799, 524); chk_swap("swap_point", 1'b1, 1'b0);
    step(0, 0);     chk_swap("swap_post", 1'b0, 1'b1);
    run_row(0, 1'b1);
    run_row(479, 1'b1);
    step(10, 500);
    wr_valid_i = 1'b1; wr_addr_i = 16'h1234; wr_data_i = 8'h5A;
    @(negedge clk_i);
    n_vec++;
    if (ram_we_o !== 1'b1 || ram_addr_o !== 17'h01234) begin
      n_err++;
      $display("FAIL wr_bank0 we/addr got %b/%h want 1/01234", ram_we_o, ram_addr_o);
    end
    step(11, 500);
    wr_valid_i = 1'b0;
    n_vec++;
    if (mem[17'h01234] !== 8'h5A) begin
      n_err++;
      $display("FAIL wr_bank0_mem got %h want 5a", mem[17'h01234]);
    end
  endtask

  task automatic test_swap_corners;
    step(799, 524); swap_req_i = 1'b1; chk_swap("coinc_point", 1'b1, 1'b1);
    step(0, 0);     swap_req_i = 1'b0; chk_swap("coinc_post", 1'b0, 1'b0);
    step(0, 50);    swap_req_i = 1'b1;
    step(1, 50);    swap_req_i = 1'b0;
    step(0, 60);    swap_req_i = 1'b1;
    step(1, 60);    swap_req_i = 1'b0; chk_swap("dbl_wait", 1'b0, 1'b0);
    step(799, 524); chk_swap("dbl_point", 1'b1, 1'b0);
    step(0, 0);     chk_swap("dbl_post", 1'b0, 1'b1);
    step(799, 524); chk_swap("dbl_nofire", 1'b0, 1'b1);
    step(0, 0);     chk_swap("dbl_hold", 1'b0, 1'b1);
  endtask

  task automatic test_midframe_reset;
    step(0, 100);   swap_req_i = 1'b1;
    step(1, 100);   swap_req_i = 1'b0;
    step(799, 500);
    step(799, 500);
    for (int c = 0; c <= 300; c++) step(c, 200);
    @(negedge clk_i);
    n_vec++;
    if (pixel_o !== exp_pix(300, 200, 1'b1)) begin
      n_err++;
      $display("FAIL pre_rst pix got %h want %h", pixel_o, exp_pix(300, 200, 1'b1));
    end
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (pixel_o !== 8'h0F || display_bank_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst pix/bank got %h/%b want 0f/0", pixel_o, display_bank_o);
    end
    step(301, 200);
    step(302, 200);
    rst_i = 1'b0;
    step(799, 524); chk_swap("rst_cleared", 1'b0, 1'b0);
    step(0, 0);     chk_swap("rst_bank", 1'b0, 1'b0);
    run_row(0, 1'b0);
    run_row(2, 1'b0);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_scanout();
        test_arbitration();
        test_swap();
        test_swap_corners();
        test_midframe_reset();
      end
      begin
        #2_000_000;
        n_err++;
        $display("FAIL timeout got running want done");
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nes_frame_scheduler.md
Name: nes_frame_scheduler

Overview:
- Arbitrates a single-port, synchronous-read frame buffer RAM between the PPU pixel writer and the VGA scan-out path.
- Maps the 640x480 VGA raster onto a 256x240 NES frame, scaled 2x and horizontally centred at columns 64..575.
- Drives the 8-bit palette index consumed by the VGA timing block, and manages double buffering with a frame-aligned bank swap.

Parameters:
- H_OFFSET, 64: first active VGA column of the NES window.
- BORDER_PIXEL, 8'h0F: palette index driven outside the window (black).
- LAST_COL, 799: final column of a VGA line.
- LAST_ROW, 524: final row of a VGA frame.

Ports:
- clk_i  in  1  pixel clock; single clock domain.
- rst_i  in  1  asynchronous active-high reset.
- column_i  in  10  current VGA column counter.
- row_i  in  10  current VGA row counter.
- pixel_o  out  8  palette index for the current column, feeding the VGA pixel input.
- wr_valid_i  in  1  PPU write request.
- wr_addr_i  in  16  NES pixel address {y[7:0], x[7:0]}.
- wr_data_i  in  8  palette index to store.
- wr_ready_o  out  1  write accepted this cycle when wr_valid_i is also high.
- swap_req_i  in  1  single-cycle pulse from the PPU: frame complete.
- swap_done_o  out  1  single-cycle pulse when the display bank flips.
- display_bank_o  out  1  bank currently being scanned out.
- ram_addr_o  out  17  {bank, y, x}.
- ram_we_o  out  1  RAM write enable.
- ram_wdata_o  out  8  RAM write data.
- ram_rdata_i  in  8  RAM read data; valid one cycle after the address.

Behaviour:
- Reset (asynchronous, active-high, all state):
  - pixel_o = BORDER_PIXEL.
  - rd_pending = 0, display_bank = 0, swap_pending = 0, swap_done_o = 0.
- Read slot, rd_slot (combinational):
  - Asserted when row_i < 480, column_i[0] == 0, and 62 <= column_i <= 573.
  - Each slot fetches the pixel that is displayed two columns later.
- Read address:
  - x = (column_i - 62) >> 1, 8 bits. y = row_i[8:1].
  - ram_addr_o = {display_bank, y, x}, ram_we_o = 0.
- Write path (combinational):
  - wr_ready_o = !rd_slot.
  - When wr_valid_i && wr_ready_o: ram_addr_o = {~display_bank, wr_addr_i}, ram_we_o = 1, ram_wdata_o = wr_data_i.
  - Otherwise ram_we_o = 0.
  - A stalled write must hold its addr/data until accepted.
  - Worst-case stall is 1 cycle; at least every other cycle is free inside the window, and every cycle is free in blanking.
  - wr_addr_i y >= 240 is written unchecked; the PPU never issues it.
- Read pipeline:
  - rd_pending <= rd_slot.
  - On each edge, evaluated in priority order:
    - if rd_pending: pixel_o <= ram_rdata_i;
    - else if (column_i + 1) is outside [H_OFFSET, H_OFFSET+511], or row_i >= 480: pixel_o <= BORDER_PIXEL;
    - else pixel_o holds.
  - Net effect: each NES pixel is shown for exactly 2 VGA columns, aligned with column_i == displayed column.
- Swap state machine, two states: IDLE and PENDING.
  - IDLE: swap_req_i moves to PENDING.
  - The swap point is column_i == LAST_COL && row_i == LAST_ROW.
  - At the swap point in PENDING, or in IDLE with swap_req_i high in that same cycle:
    - display_bank toggles;
    - swap_done_o pulses for 1 cycle;
    - state returns to IDLE.
  - swap_req_i while already PENDING is absorbed; only one flip occurs.
  - Writes issued during the swap-point cycle still target the old back bank; the bank change is visible from the next cycle.
- Mid-frame reset:
  - All registers return to reset values immediately.
  - Scan-out resumes correctly as soon as the counters restart; no other recovery sequence is required.

Test Plan:
1. Reset: hold rst_i with arbitrary counters. Expect pixel_o = 8'h0F, ram_we_o = 0, display_bank_o = 0, swap_done_o = 0, asynchronously.
2. Scan-out: preload bank 0 with addr {y, x} = x ^ y, run a full frame with no writes.
   - pixel_o at column c, row r equals ((c-64)>>1) ^ (r>>1) for c in 64..575, r < 480.
   - pixel_o = 8'h0F elsewhere.
   - Check edge columns 63, 64, 65, 575, 576.
3. Arbitration: hold wr_valid_i high continuously through row 10.
   - wr_ready_o = 0 exactly at even columns 62..572; ram_we_o never coincides with a read slot.
   - Every write lands in bank 1 with the correct data.
4. Swap: pulse swap_req_i at row 100.
   - swap_done_o pulses once, at column 799 / row 524.
   - display_bank_o = 1 from the next cycle; the next frame shows bank 1 contents.
   - Writes now go to bank 0.
5. Swap corner cases:
   - swap_req_i coincident with the swap point flips the bank that cycle.
   - Two requests in one frame produce a single flip.
6. Reset mid-line at column 300, row 200, then release.
   - pixel_o = 8'h0F, swap_pending cleared.
   - Correct scan-out resumes once the counters restart at 0/0.
